// File: rtl/delay_stage_arbiter.sv
// Two-requester round-robin arbiter with bounded burst ownership, feeding one
// registered 1-cycle delay stage with a valid/ready output handshake.
module delay_stage_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST      = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  req_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic                  gnt_a,
   input  logic                  req_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic                  gnt_b,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_src
);

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_A     = 2'd1;
   localparam logic [1:0] OWN_B     = 2'd2;
   localparam logic [3:0] BURST_MAX = 4'(BURST);

   logic [1:0]            owner_q, owner_d;
   logic [3:0]            burst_q, burst_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  src_q, src_d;
   logic                  slot_free;
   logic [1:0]            winner;

   assign slot_free = !valid_q || out_ready;

   // Owner keeps priority only while requesting and under its burst limit;
   // an uncontested owner may keep winning past the limit.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (n_rst && slot_free) begin
         case (owner_q)
            OWN_A: begin
               if (req_a && (burst_q < BURST_MAX)) gnt_a = 1'b1;
               else if (req_b)                     gnt_b = 1'b1;
               else if (req_a)                     gnt_a = 1'b1;
            end
            OWN_B: begin
               if (req_b && (burst_q < BURST_MAX)) gnt_b = 1'b1;
               else if (req_a)                     gnt_a = 1'b1;
               else if (req_b)                     gnt_b = 1'b1;
            end
            default: begin
               if (req_a)      gnt_a = 1'b1;
               else if (req_b) gnt_b = 1'b1;
            end
         endcase
      end
   end

   assign winner = gnt_b ? OWN_B : OWN_A;

   always_comb begin
      owner_d = owner_q;
      burst_d = burst_q;
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      if (gnt_a || gnt_b) begin
         data_d  = gnt_b ? data_b : data_a;
         src_d   = gnt_b;
         valid_d = 1'b1;
         if (winner == owner_q) begin
            burst_d = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;
         end else begin
            owner_d = winner;
            burst_d = 4'd1;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         owner_q <= OWN_NONE;
         burst_q <= 4'd0;
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= 1'b0;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: tb/tb_delay_stage_arbiter.sv
// Directed, table-driven bench for delay_stage_arbiter (BURST=4).
module tb_delay_stage_arbiter;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        req_a, req_b, out_ready;
   logic [31:0] data_a, data_b;
   logic        gnt_a, gnt_b, out_valid, out_src;
   logic [31:0] out_data;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        ra;
      logic [31:0] da;
      logic        rb;
      logic [31:0] db;
      logic        rdy;
      logic        ega;
      logic        egb;
      logic        evld;
      logic [31:0] edat;
      logic        esrc;
   } vec_t;

   vec_t tbl[$];

   delay_stage_arbiter #(.DATA_WIDTH(32), .BURST(4)) dut (
      .clk(clk), .n_rst(n_rst),
      .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
      .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
      .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_src(out_src)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic ra, input logic [31:0] da, input logic rb,
                      input logic [31:0] db, input logic rdy, input logic ega,
                      input logic egb, input logic evld, input logic [31:0] edat,
                      input logic esrc);
      vec_t v;
      v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.rdy = rdy;
      v.ega = ega; v.egb = egb; v.evld = evld; v.edat = edat; v.esrc = esrc;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      req_a = v.ra; data_a = v.da; req_b = v.rb; data_b = v.db; out_ready = v.rdy;
      #1;
      chk($sformatf("v%0d gnt_a", idx), {31'd0, gnt_a}, {31'd0, v.ega});
      chk($sformatf("v%0d gnt_b", idx), {31'd0, gnt_b}, {31'd0, v.egb});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.evld});
      chk($sformatf("v%0d out_data", idx), out_data, v.edat);
      chk($sformatf("v%0d out_src", idx), {31'd0, out_src}, {31'd0, v.esrc});
   endtask

   initial begin
      logic pat [9];
      // single requester A, continuing past BURST
      for (int i = 0; i < 6; i++)
         add(1, 32'd10034 + 32'(i), 0, 0, 1, 1, 0, 1, 32'd10034 + 32'(i), 0);
      // drain: valid drops, data and src retained
      add(0, 0, 0, 0, 1, 0, 0, 0, 32'd10039, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 32'd10039, 0);
      // contention; A is saturated owner so B goes first
      for (int i = 0; i < 4; i++)
         add(1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 0, 1, 1, 32'hBBBB0001, 1);
      for (int i = 0; i < 4; i++)
         add(1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 1, 0, 1, 32'hAAAA0001, 0);
      add(1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 0, 1, 1, 32'hBBBB0001, 1);
      // backpressure with B requesting
      for (int i = 0; i < 3; i++)
         add(0, 0, 1, 32'd99009900, 0, 0, 0, 1, 32'hBBBB0001, 1);
      add(0, 0, 1, 32'd99009900, 1, 0, 1, 1, 32'd99009900, 1);
      // owner release: A builds burst 2, drops, B takes over for 4 transfers
      add(1, 32'h0000A4A4, 0, 32'h0000B4B4, 1, 1, 0, 1, 32'h0000A4A4, 0);
      add(1, 32'h0000A4A4, 0, 32'h0000B4B4, 1, 1, 0, 1, 32'h0000A4A4, 0);
      add(0, 32'h0000A4A4, 1, 32'h0000B4B4, 1, 0, 1, 1, 32'h0000B4B4, 1);
      for (int i = 0; i < 3; i++)
         add(1, 32'h0000A4A4, 1, 32'h0000B4B4, 1, 0, 1, 1, 32'h0000B4B4, 1);
      add(1, 32'h0000A4A4, 1, 32'h0000B4B4, 1, 1, 0, 1, 32'h0000A4A4, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 32'h0000A4A4, 0);

      n_rst = 1'b0;
      req_a = 0; req_b = 0; data_a = 0; data_b = 0; out_ready = 0;
      #1;
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_data", out_data, 32'd0);
      chk("rst out_src", {31'd0, out_src}, 32'd0);
      req_a = 1;
      #1;
      chk("rst gnt_a", {31'd0, gnt_a}, 32'd0);
      req_a = 0;
      @(negedge clk);
      @(negedge clk);
      #2 n_rst = 1'b1;

      foreach (tbl[i]) apply(tbl[i], i);

      // asynchronous reset while a word is held
      @(negedge clk);
      req_a = 1; data_a = 32'h12345678; req_b = 0; out_ready = 1;
      @(posedge clk);
      #1;
      chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 0;
      #2 n_rst = 1'b0;
      #1;
      chk("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid-rst out_data", out_data, 32'd0);
      chk("mid-rst out_src", {31'd0, out_src}, 32'd0);
      chk("mid-rst gnt_a", {31'd0, gnt_a}, 32'd0);
      #2 n_rst = 1'b1;
      req_a = 0; req_b = 0; out_ready = 1;

      // fresh contention: A,A,A,A,B,B,B,B,A
      pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         req_a = 1; data_a = 32'hC0C000AA; req_b = 1; data_b = 32'hC0C000BB;
         #1;
         chk($sformatf("rr%0d gnt_a", i), {31'd0, gnt_a}, {31'd0, !pat[i]});
         chk($sformatf("rr%0d gnt_b", i), {31'd0, gnt_b}, {31'd0, pat[i]});
         @(posedge clk);
         #1;
         chk($sformatf("rr%0d out_src", i), {31'd0, out_src}, {31'd0, pat[i]});
         chk($sformatf("rr%0d out_data", i), out_data,
             pat[i] ? 32'hC0C000BB : 32'hC0C000AA);
         chk($sformatf("rr%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/delay_stage_arbiter.md
Name: delay_stage_arbiter

Overview:
Shares one registered single-clock delay stage (32-bit, 1-cycle latency) between two requesters, A and B.
Arbitration is round-robin with bounded burst ownership. The winning word is captured into the stage register and presented downstream with a valid/ready handshake.
Sits in front of the delay-stage datapath wherever two producers feed one pipelined consumer.

Parameters:
DATA_WIDTH, 32, width of data_a, data_b and out_data
BURST, 4, max consecutive transfers one requester may win while the other is requesting (range 1..15)

Ports:
clk  input  1  system clock, rising-edge active
n_rst  input  1  asynchronous active-low reset
req_a  input  1  requester A has a word; data_a held stable while high
data_a  input  DATA_WIDTH  requester A data
gnt_a  output  1  combinational grant to A; transfer occurs on the rising edge where gnt_a=1
req_b  input  1  requester B has a word
data_b  input  DATA_WIDTH  requester B data
gnt_b  output  1  combinational grant to B
out_ready  input  1  downstream accepts out_data this cycle
out_valid  output  1  stage register holds an unconsumed word
out_data  output  DATA_WIDTH  registered stage word
out_src  output  1  source of out_data: 0=A, 1=B

Behaviour:
- One clock (clk); reset is asynchronous and active-low (n_rst).
- Reset values, applied immediately and asynchronously:
  - out_valid=0, out_data=0, out_src=0
  - owner=NONE, burst_cnt=0
  - gnt_a=gnt_b=0 while n_rst=0
- A reset asserted mid-operation drops any held word. No partial state survives.
- slot_free = !out_valid || out_ready. When slot_free=0 (stall), gnt_a=gnt_b=0 and all state holds.
- Grants are mutually exclusive. Each is asserted only with its own req high and slot_free=1.
- Internal state: owner ∈ {NONE, A, B}; burst_cnt, 4 bits, saturates at BURST.
- Grant selection, when slot_free=1, in priority order:
  1. owner=NONE: A if req_a, else B if req_b.
  2. owner's req high and burst_cnt<BURST: grant owner.
  3. other requester's req high: grant other.
  4. owner's req high: grant owner (burst may exceed BURST while uncontested; burst_cnt stays saturated).
  5. Otherwise no grant.
- On transfer (gnt_x=1 at the rising edge):
  - out_data<=data_x, out_src<=x, out_valid<=1.
  - If x==owner: burst_cnt<=min(burst_cnt+1, BURST).
  - Else: owner<=x, burst_cnt<=1.
- No transfer and out_ready=1: out_valid<=0. out_data and out_src retain their last values.
- Simultaneous drain and fill: when out_valid=1, out_ready=1 and a grant occurs, the old word is consumed and the new word is loaded on the same edge; out_valid stays 1.
- Latency: data_x is visible on out_data one clock after the grant edge.
- Throughput: one word per cycle while out_ready=1.
- An owner dropping req releases priority immediately; burst_cnt is not cleared until a different requester wins.
- The requester owns data stability. The block samples data only on grant edges.

Test Plan:
- Reset: n_rst=0 pulsed mid-cycle with out_valid=1 -> out_valid=0, out_data=0 asynchronously; the first grant after release goes to A when both req.
- Single requester: req_a=1, data_a=32'd10034, out_ready=1 -> gnt_a=1; out_data=10034, out_src=0, out_valid=1 on the next negedge; continuous grants continue past BURST with B idle.
- Contention, BURST=4, both req held, out_ready=1 -> grant pattern A,A,A,A,B,B,B,B,A…; out_src sequence matches one cycle later.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_b=1, data_b=32'd99009900 -> gnt_b=0 and out_data held; out_ready=1 -> gnt_b=1 the same cycle, out_data=99009900 next cycle, out_valid never drops.
- Owner release: A owns with burst_cnt=2; req_a drops, req_b=1 -> B granted the next free cycle, burst_cnt=1; req_a returns -> B keeps the grant until it has 4 transfers.
- Drain: single transfer then requests stop, out_ready=1 -> out_valid=1 for exactly one cycle, then 0; out_data retains the last value.
